// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among N_REQ byte-stream
// requesters; a grant lasts one packet unless the burst cap forces an early release.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned NB_REQ_IDX = 2,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0]   i_req_data,
    input  logic [N_REQ-1:0]           i_req_last,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic                       o_tx_start,
    output logic [NB_DATA-1:0]         o_tx_data,
    input  logic                       i_tx_done,
    output logic [NB_REQ_IDX-1:0]      o_grant_id,
    output logic                       o_grant_valid,
    output logic                       o_busy
);

    localparam int unsigned           NB_CNT   = 8;
    localparam logic [NB_REQ_IDX-1:0] LAST_IDX = NB_REQ_IDX'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, START, WAIT} state_t;

    state_t                state;
    logic [NB_REQ_IDX-1:0] rr_ptr;
    logic [NB_CNT-1:0]     burst_cnt;
    logic                  last_q;
    logic [NB_DATA-1:0]    req_bytes [N_REQ];
    logic                  pick_found;
    logic [NB_REQ_IDX-1:0] pick_idx;
    int unsigned           cand;
    logic                  handshake;
    logic                  release_grant;
    logic [NB_REQ_IDX-1:0] next_ptr;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign req_bytes[g] = i_req_data[g*NB_DATA +: NB_DATA];
    end

    // Scan farthest-to-nearest from rr_ptr so the last hit is the nearest valid requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            cand = (32'(rr_ptr) + 32'(i)) % N_REQ;
            if (i_req_valid[NB_REQ_IDX'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = NB_REQ_IDX'(cand);
            end
        end
    end

    assign handshake     = (state == ISSUE) && i_req_valid[o_grant_id];
    assign release_grant = last_q || ((MAX_BURST != 0) && (burst_cnt == NB_CNT'(MAX_BURST)));
    assign next_ptr      = (o_grant_id == LAST_IDX) ? '0 : o_grant_id + NB_REQ_IDX'(1);
    assign o_req_ready   = (state == ISSUE) ? (i_req_valid & (N_REQ'(1) << o_grant_id)) : '0;

    // Packet-level FSM; tx_done is honoured only in WAIT.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            burst_cnt     <= '0;
            last_q        <= 1'b0;
            o_tx_start    <= 1'b0;
            o_tx_data     <= '0;
            o_grant_id    <= '0;
            o_grant_valid <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        o_grant_id    <= pick_idx;
                        o_grant_valid <= 1'b1;
                        o_busy        <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        o_tx_data  <= req_bytes[o_grant_id];
                        last_q     <= i_req_last[o_grant_id];
                        burst_cnt  <= burst_cnt + NB_CNT'(1);
                        o_tx_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (i_tx_done) begin
                        if (release_grant) begin
                            rr_ptr        <= next_ptr;
                            burst_cnt     <= '0;
                            o_grant_valid <= 1'b0;
                            o_busy        <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance 0 uses the default burst cap, instance 1
// a cap of 2; each drives a behavioural serializer whose line is decoded back to bytes.
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned NB_DATA = 8;
    localparam int unsigned N_INST  = 2;
    localparam int unsigned DEPTH   = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester packet queues: {last, byte} per entry, popped on valid&ready.
    logic [8:0] pkt_mem [N_INST][N_REQ][DEPTH];
    int         pkt_len [N_INST][N_REQ];
    int         pkt_pos [N_INST][N_REQ];
    logic       inj_done [N_INST];

    // Serializer and line-receiver models plus start/receive logs.
    logic [9:0] sh [N_INST];
    int         sh_cnt [N_INST];
    logic       line [N_INST];
    logic       model_done [N_INST];
    logic [7:0] held [N_INST];
    logic       rx_busy [N_INST];
    int         rx_cnt [N_INST];
    logic [7:0] rx_sh [N_INST];
    logic [8:0] rx_log [N_INST][DEPTH];
    int         n_rx [N_INST];
    logic [9:0] start_log [N_INST][DEPTH];
    int         n_start [N_INST];
    logic [9:0] exp_q [$];

    wire [N_REQ-1:0]         req_valid [N_INST];
    wire [N_REQ*NB_DATA-1:0] req_data [N_INST];
    wire [N_REQ-1:0]         req_last [N_INST];
    wire [N_REQ-1:0]         req_ready [N_INST];
    wire                     tx_start [N_INST];
    wire [NB_DATA-1:0]       tx_data [N_INST];
    wire                     tx_done [N_INST];
    wire [1:0]               grant_id [N_INST];
    wire                     grant_valid [N_INST];
    wire                     busy [N_INST];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar k = 0; k < N_INST; k++) begin : g_inst
        for (genvar r = 0; r < N_REQ; r++) begin : g_req
            assign req_valid[k][r] = pkt_pos[k][r] < pkt_len[k][r];
            assign req_data[k][r*NB_DATA +: NB_DATA] = pkt_mem[k][r][6'(pkt_pos[k][r])][7:0];
            assign req_last[k][r] = pkt_mem[k][r][6'(pkt_pos[k][r])][8];
        end
        assign tx_done[k] = model_done[k] | inj_done[k];

        uart_tx_arbiter #(
            .N_REQ      (N_REQ),
            .NB_DATA    (NB_DATA),
            .NB_REQ_IDX (2),
            .MAX_BURST  (k == 0 ? 16 : 2)
        ) u_dut (
            .i_clk         (clk),
            .i_reset_n     (rst_n),
            .i_req_valid   (req_valid[k]),
            .i_req_data    (req_data[k]),
            .i_req_last    (req_last[k]),
            .o_req_ready   (req_ready[k]),
            .o_tx_start    (tx_start[k]),
            .o_tx_data     (tx_data[k]),
            .i_tx_done     (tx_done[k]),
            .o_grant_id    (grant_id[k]),
            .o_grant_valid (grant_valid[k]),
            .o_busy        (busy[k])
        );
    end

    // Serializer: start, 8 data bits LSB first, stop, one bit per cycle, done with the stop bit.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < N_INST; k++) begin
            if (!rst_n) begin
                sh_cnt[k]     <= 0;
                line[k]       <= 1'b1;
                model_done[k] <= 1'b0;
                rx_busy[k]    <= 1'b0;
                rx_cnt[k]     <= 0;
            end else begin
                for (int r = 0; r < N_REQ; r++)
                    if (req_valid[k][r] && req_ready[k][r]) pkt_pos[k][r] <= pkt_pos[k][r] + 1;
                if (tx_start[k]) begin
                    start_log[k][6'(n_start[k])] <= {grant_id[k], tx_data[k]};
                    n_start[k] <= n_start[k] + 1;
                end
                model_done[k] <= 1'b0;
                if (sh_cnt[k] == 0) begin
                    if (tx_start[k]) begin
                        sh[k]     <= {1'b1, tx_data[k], 1'b0};
                        sh_cnt[k] <= 10;
                        held[k]   <= tx_data[k];
                    end
                end else begin
                    line[k]   <= sh[k][0];
                    sh[k]     <= {1'b1, sh[k][9:1]};
                    sh_cnt[k] <= sh_cnt[k] - 1;
                    if (sh_cnt[k] == 1) begin
                        model_done[k] <= 1'b1;
                        check("tx_data_hold", 32'(tx_data[k]), 32'(held[k]));
                    end
                end
                if (!rx_busy[k]) begin
                    if (line[k] == 1'b0) begin
                        rx_busy[k] <= 1'b1;
                        rx_cnt[k]  <= 0;
                    end
                end else if (rx_cnt[k] < 8) begin
                    rx_sh[k]  <= {line[k], rx_sh[k][7:1]};
                    rx_cnt[k] <= rx_cnt[k] + 1;
                end else begin
                    rx_busy[k] <= 1'b0;
                    rx_log[k][6'(n_rx[k])] <= {line[k], rx_sh[k]};
                    n_rx[k] <= n_rx[k] + 1;
                end
            end
        end
    end

    task automatic push(input int k, input int r, input logic [7:0] b, input logic l);
        pkt_mem[k][r][6'(pkt_len[k][r])] = {l, b};
        pkt_len[k][r] = pkt_len[k][r] + 1;
    endtask

    function automatic logic drained(input int k);
        drained = 1'b1;
        for (int r = 0; r < N_REQ; r++)
            if (pkt_pos[k][r] != pkt_len[k][r]) drained = 1'b0;
    endfunction

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        while (!(drained(k) && !busy[k] && sh_cnt[k] == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_in_budget", 32'(n < budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_seq(input int k, input int sb, input int rb);
        check("start_count", 32'(n_start[k] - sb), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check("start_gid", 32'(start_log[k][6'(sb + i)][9:8]), 32'(exp_q[i][9:8]));
            check("start_byte", 32'(start_log[k][6'(sb + i)][7:0]), 32'(exp_q[i][7:0]));
            check("line_byte", 32'(rx_log[k][6'(rb + i)]), 32'({1'b1, exp_q[i][7:0]}));
        end
        exp_q.delete();
    endtask

    task automatic check_zero(input int k);
        check("z_ready", 32'(req_ready[k]), 32'd0);
        check("z_start", 32'(tx_start[k]), 32'd0);
        check("z_data", 32'(tx_data[k]), 32'd0);
        check("z_gid", 32'(grant_id[k]), 32'd0);
        check("z_gvalid", 32'(grant_valid[k]), 32'd0);
        check("z_busy", 32'(busy[k]), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int sb;
        int rb;
        inj_done[0] = 1'b0;
        inj_done[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte: ready in cycle 1, start in cycle 2, then release with pointer 1.
        sb = n_start[0]; rb = n_rx[0];
        push(0, 0, 8'hA5, 1'b1);
        check("t1_ready_c0", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        check("t1_ready_c1", 32'(req_ready[0]), 32'b0001);
        check("t1_gvalid_c1", 32'(grant_valid[0]), 32'd1);
        check("t1_busy_c1", 32'(busy[0]), 32'd1);
        check("t1_start_c1", 32'(tx_start[0]), 32'd0);
        @(negedge clk);
        check("t1_start_c2", 32'(tx_start[0]), 32'd1);
        check("t1_data_c2", 32'(tx_data[0]), 32'hA5);
        check("t1_ready_c2", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        check("t1_start_c3", 32'(tx_start[0]), 32'd0);
        check("t1_data_c3", 32'(tx_data[0]), 32'hA5);
        wait_idle(0, 100);
        check("t1_busy_end", 32'(busy[0]), 32'd0);
        check("t1_gvalid_end", 32'(grant_valid[0]), 32'd0);
        exp_q.push_back({2'd0, 8'hA5});
        expect_seq(0, sb, rb);

        // Pointer is 1 after the first release, so req1 wins over req0.
        sb = n_start[0]; rb = n_rx[0];
        push(0, 0, 8'h01, 1'b1);
        push(0, 1, 8'h02, 1'b1);
        @(negedge clk);
        check("ptr_gid", 32'(grant_id[0]), 32'd1);
        wait_idle(0, 200);
        exp_q.push_back({2'd1, 8'h02});
        exp_q.push_back({2'd0, 8'h01});
        expect_seq(0, sb, rb);

        // Two 3-byte packets after reset: req0's packet completes before req2's.
        do_reset();
        sb = n_start[0]; rb = n_rx[0];
        push(0, 0, 8'h10, 1'b0); push(0, 0, 8'h11, 1'b0); push(0, 0, 8'h12, 1'b1);
        push(0, 2, 8'h20, 1'b0); push(0, 2, 8'h21, 1'b0); push(0, 2, 8'h22, 1'b1);
        wait_idle(0, 400);
        exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd0, 8'h11});
        exp_q.push_back({2'd0, 8'h12}); exp_q.push_back({2'd2, 8'h20});
        exp_q.push_back({2'd2, 8'h21}); exp_q.push_back({2'd2, 8'h22});
        expect_seq(0, sb, rb);

        // All four continuously valid with 1-byte packets: strict 0,1,2,3 rotation.
        do_reset();
        sb = n_start[0]; rb = n_rx[0];
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 4; r++) begin
                push(0, r, 8'(8'h40 + 16 * p + r), 1'b1);
                exp_q.push_back({2'(r), 8'(8'h40 + 16 * p + r)});
            end
        wait_idle(0, 600);
        expect_seq(0, sb, rb);

        // Burst cap 2: req1's 5-byte packet interleaves with req3's two packets.
        sb = n_start[1]; rb = n_rx[1];
        push(1, 1, 8'hB1, 1'b0); push(1, 1, 8'hB2, 1'b0); push(1, 1, 8'hB3, 1'b0);
        push(1, 1, 8'hB4, 1'b0); push(1, 1, 8'hB5, 1'b1);
        push(1, 3, 8'h31, 1'b1); push(1, 3, 8'h32, 1'b1);
        wait_idle(1, 600);
        exp_q.push_back({2'd1, 8'hB1}); exp_q.push_back({2'd1, 8'hB2});
        exp_q.push_back({2'd3, 8'h31}); exp_q.push_back({2'd1, 8'hB3});
        exp_q.push_back({2'd1, 8'hB4}); exp_q.push_back({2'd3, 8'h32});
        exp_q.push_back({2'd1, 8'hB5});
        expect_seq(1, sb, rb);

        // Stray done pulses in IDLE, ISSUE and START are ignored.
        sb = n_start[0]; rb = n_rx[0];
        inj_done[0] = 1'b1;
        @(negedge clk);
        check("t5_idle_busy", 32'(busy[0]), 32'd0);
        push(0, 2, 8'h5A, 1'b1);
        @(negedge clk);
        check("t5_issue_ready", 32'(req_ready[0]), 32'b0100);
        @(negedge clk);
        check("t5_start", 32'(tx_start[0]), 32'd1);
        @(negedge clk);
        inj_done[0] = 1'b0;
        check("t5_wait_busy", 32'(busy[0]), 32'd1);
        check("t5_wait_start", 32'(tx_start[0]), 32'd0);
        wait_idle(0, 200);
        exp_q.push_back({2'd2, 8'h5A});
        expect_seq(0, sb, rb);

        // Open packet with no next byte holds in ISSUE; done pulses there change nothing.
        sb = n_start[0]; rb = n_rx[0];
        push(0, 1, 8'h61, 1'b0);
        repeat (20) @(negedge clk);
        inj_done[0] = 1'b1;
        repeat (3) @(negedge clk);
        inj_done[0] = 1'b0;
        check("hold_busy", 32'(busy[0]), 32'd1);
        check("hold_gvalid", 32'(grant_valid[0]), 32'd1);
        check("hold_gid", 32'(grant_id[0]), 32'd1);
        check("hold_ready", 32'(req_ready[0]), 32'd0);
        check("hold_starts", 32'(n_start[0] - sb), 32'd1);
        push(0, 1, 8'h62, 1'b1);
        wait_idle(0, 200);
        exp_q.push_back({2'd1, 8'h61});
        exp_q.push_back({2'd1, 8'h62});
        expect_seq(0, sb, rb);

        // Reset during WAIT clears outputs at once; arbitration restarts from pointer 0.
        push(0, 3, 8'h77, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_wait_busy", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb = n_start[0]; rb = n_rx[0];
        push(0, 1, 8'h81, 1'b1);
        push(0, 3, 8'h83, 1'b1);
        @(negedge clk);
        check("t6_gid_after_rst", 32'(grant_id[0]), 32'd1);
        wait_idle(0, 300);
        exp_q.push_back({2'd1, 8'h81});
        exp_q.push_back({2'd3, 8'h83});
        expect_seq(0, sb, rb);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
